rom_port_arbiter: RTL

- Shares the single ROM read port between two requesters: instruction fetch (IF) and load unit (LS).
- Arbitrates between the two requesters round-robin.
- Drives ROM address and read-enable from registers and captures the 4-byte ROM read data.
- Assembles byte, half or word results, range-checks addresses and returns data with a one-cycle ack pulse.
- Sits in the LSU between the fetch/load logic and the ROM.

---
 rtl/rom_port_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one ROM read port between instruction fetch and the load unit.
// Registers ROM address/enable, assembles byte/half/word results and range-checks requests.
module rom_port_arbiter #(
    parameter logic [15:0] ROM_BASE = 16'h8000,
    parameter logic [15:0] ROM_LAST = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_data,
    output logic        if_err,
    input  logic        ls_req,
    input  logic [15:0] ls_addr,
    input  logic [1:0]  ls_size,
    output logic        ls_ack,
    output logic [31:0] ls_data,
    output logic        ls_err,
    output logic [15:0] rom_a,
    output logic        rom_re,
    input  logic [7:0]  rom_q0,
    input  logic [7:0]  rom_q1,
    input  logic [7:0]  rom_q2,
    input  logic [7:0]  rom_q3
);

    typedef enum logic [1:0] {IDLE, READ, WAIT, RESP} state_t;

    state_t      state_reg;
    logic        owner_ls_reg;
    logic        last_ls_reg;
    logic [1:0]  size_reg;

    logic        grant_ls;
    logic [15:0] grant_addr;
    logic [1:0]  grant_size;
    logic        grant_legal;
    logic [31:0] rd_data;

    // LS wins only when IF is idle or IF was the last one served.
    assign grant_ls    = ls_req && (!if_req || !last_ls_reg);
    assign grant_addr  = grant_ls ? ls_addr : if_addr;
    assign grant_size  = grant_ls ? ls_size : 2'd2;
    assign grant_legal = (grant_addr >= ROM_BASE) && (grant_addr <= ROM_LAST) &&
                         (grant_size != 2'd3);

    always_comb begin
        rd_data = {rom_q3, rom_q2, rom_q1, rom_q0};
        case (size_reg)
            2'd0:    rd_data = {24'h0, rom_q0};
            2'd1:    rd_data = {16'h0, rom_q1, rom_q0};
            default: rd_data = {rom_q3, rom_q2, rom_q1, rom_q0};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            owner_ls_reg <= 1'b0;
            last_ls_reg  <= 1'b1;
            size_reg     <= 2'd0;
            rom_a        <= 16'h0;
            rom_re       <= 1'b0;
            if_ack       <= 1'b0;
            if_data      <= 32'h0;
            if_err       <= 1'b0;
            ls_ack       <= 1'b0;
            ls_data      <= 32'h0;
            ls_err       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (if_req || ls_req) begin
                        owner_ls_reg <= grant_ls;
                        last_ls_reg  <= grant_ls;
                        size_reg     <= grant_size;
                        if (grant_legal) begin
                            rom_a     <= grant_addr;
                            rom_re    <= 1'b1;
                            state_reg <= READ;
                        end else begin
                            if (grant_ls) begin
                                ls_data <= 32'h0;
                                ls_err  <= 1'b1;
                                ls_ack  <= 1'b1;
                            end else begin
                                if_data <= 32'h0;
                                if_err  <= 1'b1;
                                if_ack  <= 1'b1;
                            end
                            state_reg <= RESP;
                        end
                    end
                end
                READ: begin
                    rom_re    <= 1'b0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (owner_ls_reg) begin
                        ls_data <= rd_data;
                        ls_err  <= 1'b0;
                        ls_ack  <= 1'b1;
                    end else begin
                        if_data <= rd_data;
                        if_err  <= 1'b0;
                        if_ack  <= 1'b1;
                    end
                    state_reg <= RESP;
                end
                RESP: begin
                    // The requester drops its request while it sees the ack, so no re-sampling here.
                    if_ack    <= 1'b0;
                    ls_ack    <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
